uart_frame_ctrl: RTL and testbench

UART_FRAME_CTRL -- requirements
Module: uart_frame_ctrl

---
 rtl/uart_frame_ctrl.sv | 177 +++++++++++++++++
 tb/tb_uart_frame_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_frame_ctrl
// Description : Parses HEADER/CMD/LEN/payload/CHK frames from an RX FIFO,
//               streams payload bytes out and flags good frames or errors.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_frame_ctrl #(
  parameter logic [7:0] HEADER      = 8'hAA,
  parameter int         MAX_LEN     = 16,
  parameter int         TIMEOUT_CYC = 50000
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_dout,
  output logic       fifo_rd_en,
  output logic       pl_we,
  output logic [3:0] pl_addr,
  output logic [7:0] pl_data,
  output logic       frame_valid,
  output logic [7:0] frame_cmd,
  output logic [4:0] frame_len,
  output logic       err_chk,
  output logic       err_len,
  output logic       err_timeout,
  output logic       busy
);

  localparam int              c_tw      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [c_tw-1:0] c_tmax    = c_tw'(TIMEOUT_CYC - 1);
  localparam logic [7:0]      c_max_len = 8'(MAX_LEN);

  typedef enum logic [2:0] {
    S_HUNT    = 3'd0,
    S_CMD     = 3'd1,
    S_LEN     = 3'd2,
    S_PAYLOAD = 3'd3,
    S_CHK     = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_pend;
  logic [7:0]      r_acc;
  logic [7:0]      r_cmd;
  logic [4:0]      r_len;
  logic [3:0]      r_idx;
  logic [c_tw-1:0] r_tcnt;
  logic            r_frame_valid;
  logic            r_err_chk;
  logic            r_err_len;
  logic [7:0]      r_frame_cmd;
  logic [4:0]      r_frame_len;

  logic w_strobe;
  logic w_valid_nxt;
  logic w_chk_nxt;
  logic w_len_nxt;
  logic w_timeout;
  logic w_pl_we;
  logic w_last;

  // Read strobe is gated by rst so it drops the instant reset asserts.
  assign fifo_rd_en = ~rst & ~fifo_empty & ~r_pend;
  assign w_strobe   = r_pend;
  assign w_last     = ({1'b0, r_idx} == (r_len - 5'd1));
  assign w_pl_we    = w_strobe && (r_state == S_PAYLOAD);

  assign pl_we       = w_pl_we;
  assign pl_addr     = w_pl_we ? r_idx : 4'd0;
  assign pl_data     = w_pl_we ? fifo_dout : 8'd0;
  assign frame_valid = r_frame_valid;
  assign frame_cmd   = r_frame_cmd;
  assign frame_len   = r_frame_len;
  assign err_chk     = r_err_chk;
  assign err_len     = r_err_len;
  assign err_timeout = w_timeout;
  assign busy        = (r_state != S_HUNT);

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_state <= S_HUNT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_valid_nxt = 1'b0;
    w_chk_nxt   = 1'b0;
    w_len_nxt   = 1'b0;
    w_timeout   = 1'b0;
    if (w_strobe) begin
      case (r_state)
        S_HUNT: begin
          if (fifo_dout == HEADER) w_state_nxt = S_CMD;
        end
        S_CMD: w_state_nxt = S_LEN;
        S_LEN: begin
          if (fifo_dout > c_max_len) begin
            w_len_nxt   = 1'b1;
            w_state_nxt = S_HUNT;
          end else if (fifo_dout == 8'd0) begin
            w_state_nxt = S_CHK;
          end else begin
            w_state_nxt = S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          if (w_last) w_state_nxt = S_CHK;
        end
        S_CHK: begin
          w_valid_nxt = (fifo_dout == r_acc);
          w_chk_nxt   = (fifo_dout != r_acc);
          w_state_nxt = S_HUNT;
        end
        default: w_state_nxt = S_HUNT;
      endcase
    end else if ((r_state != S_HUNT) && (r_tcnt == c_tmax)) begin
      // A strobe in the same cycle wins, hence the else branch.
      w_timeout   = 1'b1;
      w_state_nxt = S_HUNT;
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_pend        <= 1'b0;
      r_acc         <= 8'd0;
      r_cmd         <= 8'd0;
      r_len         <= 5'd0;
      r_idx         <= 4'd0;
      r_tcnt        <= '0;
      r_frame_valid <= 1'b0;
      r_err_chk     <= 1'b0;
      r_err_len     <= 1'b0;
      r_frame_cmd   <= 8'd0;
      r_frame_len   <= 5'd0;
    end else begin
      r_pend        <= fifo_rd_en;
      r_frame_valid <= w_valid_nxt;
      r_err_chk     <= w_chk_nxt;
      r_err_len     <= w_len_nxt;
      if (w_strobe || (r_state == S_HUNT)) begin
        r_tcnt <= '0;
      end else begin
        r_tcnt <= r_tcnt + c_tw'(1);
      end
      if (w_valid_nxt) begin
        r_frame_cmd <= r_cmd;
        r_frame_len <= r_len;
      end
      if (w_strobe) begin
        case (r_state)
          S_CMD: begin
            r_cmd <= fifo_dout;
            r_acc <= fifo_dout;
          end
          S_LEN: begin
            r_len <= fifo_dout[4:0];
            r_acc <= r_acc + fifo_dout;
            r_idx <= 4'd0;
          end
          S_PAYLOAD: begin
            r_acc <= r_acc + fifo_dout;
            r_idx <= r_idx + 4'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_frame_ctrl
// Description : Directed scoreboard bench for uart_frame_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_frame_ctrl;

  logic       clk_in = 1'b0;
  logic       rst;
  logic       fifo_empty;
  logic [7:0] fifo_dout;
  logic       fifo_rd_en;
  logic       pl_we;
  logic [3:0] pl_addr;
  logic [7:0] pl_data;
  logic       frame_valid;
  logic [7:0] frame_cmd;
  logic [4:0] frame_len;
  logic       err_chk;
  logic       err_len;
  logic       err_timeout;
  logic       busy;

  uart_frame_ctrl #(
    .HEADER     (8'hAA),
    .MAX_LEN    (16),
    .TIMEOUT_CYC(20)
  ) dut (
    .clk_in     (clk_in),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_rd_en (fifo_rd_en),
    .pl_we      (pl_we),
    .pl_addr    (pl_addr),
    .pl_data    (pl_data),
    .frame_valid(frame_valid),
    .frame_cmd  (frame_cmd),
    .frame_len  (frame_len),
    .err_chk    (err_chk),
    .err_len    (err_len),
    .err_timeout(err_timeout),
    .busy       (busy)
  );

  always #5 clk_in = ~clk_in;

  localparam logic [2:0] c_k_wr  = 3'd1;
  localparam logic [2:0] c_k_val = 3'd2;
  localparam logic [2:0] c_k_chk = 3'd3;
  localparam logic [2:0] c_k_len = 3'd4;
  localparam logic [2:0] c_k_tmo = 3'd5;

  typedef struct packed {
    logic [2:0] kind;
    logic [7:0] a;
    logic [7:0] b;
  } ev_t;

  logic [7:0] fq[$];
  ev_t        exp_q[$];
  int         vectors     = 0;
  int         miscompares = 0;
  time        last_take_t = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic [7:0] b);
    fq.push_back(b);
  endtask

  task automatic expect_ev(input logic [2:0] k, input logic [7:0] a, input logic [7:0] b);
    ev_t e;
    e.kind = k;
    e.a    = a;
    e.b    = b;
    exp_q.push_back(e);
  endtask

  task automatic wait_idle(input string tag);
    bit done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk_in);
      if (fq.size() == 0 && exp_q.size() == 0 && !busy && !fifo_rd_en) done = 1'b1;
    end
    repeat (3) @(negedge clk_in);
    check({tag, "_drain"}, {31'd0, done}, 32'd1);
  endtask

  // RX FIFO model: pops on a sampled read strobe, data appears next cycle.
  initial begin
    bit take;
    fifo_empty = 1'b1;
    fifo_dout  = 8'd0;
    forever begin
      @(negedge clk_in);
      take = fifo_rd_en;
      if (take) last_take_t = $time;
      @(posedge clk_in);
      #1;
      if (take && fq.size() > 0) fifo_dout = fq.pop_front();
      fifo_empty = (fq.size() == 0);
    end
  end

  // Output monitor: every pulse or write must match the scoreboard head.
  initial begin
    int  nact;
    ev_t obs;
    ev_t e;
    forever begin
      @(negedge clk_in);
      if (rst !== 1'b1) begin
        nact = int'(pl_we) + int'(frame_valid) + int'(err_chk) + int'(err_len) + int'(err_timeout);
        if (nact != 0) begin
          check("one_hot_pulse", {31'd0, nact > 1}, 32'd0);
          obs = '0;
          if (pl_we) begin
            obs.kind = c_k_wr; obs.a = {4'd0, pl_addr}; obs.b = pl_data;
          end else if (frame_valid) begin
            obs.kind = c_k_val; obs.a = frame_cmd; obs.b = {3'd0, frame_len};
          end else if (err_chk) begin
            obs.kind = c_k_chk; obs.a = frame_cmd; obs.b = {3'd0, frame_len};
          end else if (err_len) begin
            obs.kind = c_k_len;
          end else begin
            obs.kind = c_k_tmo;
          end
          check("expected_event", {31'd0, exp_q.size() != 0}, 32'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("event", {13'd0, obs}, {13'd0, e});
          end
        end
      end
    end
  end

  initial begin
    time t_seen;
    bit  seen;
    rst = 1'b1;
    repeat (3) @(negedge clk_in);
    check("rst_outs", {fifo_rd_en, pl_we, pl_addr, pl_data, frame_valid, frame_cmd,
                       frame_len, err_chk, err_len, err_timeout, busy}, 32'd0);
    push(8'h00);
    repeat (3) @(negedge clk_in);
    check("rst_rd_gate", {31'd0, fifo_rd_en}, 32'd0);
    rst = 1'b0;
    wait_idle("rst_release");

    // Basic two-byte frame
    push(8'hAA); push(8'h12); push(8'h02); push(8'h34); push(8'h56); push(8'h9E);
    expect_ev(c_k_wr, 8'h00, 8'h34);
    expect_ev(c_k_wr, 8'h01, 8'h56);
    expect_ev(c_k_val, 8'h12, 8'h02);
    wait_idle("basic");

    // Garbage ahead of a zero-length frame
    push(8'h00); push(8'hFF); push(8'hAA); push(8'h05); push(8'h00); push(8'h05);
    expect_ev(c_k_val, 8'h05, 8'h00);
    wait_idle("zero_len");

    // Bad checksum: payload still written, frame info held at 05/0
    push(8'hAA); push(8'h12); push(8'h02); push(8'h34); push(8'h56); push(8'h00);
    expect_ev(c_k_wr, 8'h00, 8'h34);
    expect_ev(c_k_wr, 8'h01, 8'h56);
    expect_ev(c_k_chk, 8'h05, 8'h00);
    wait_idle("bad_chk");
    check("chk_hold_cmd", {24'd0, frame_cmd}, 32'h05);
    check("chk_hold_len", {27'd0, frame_len}, 32'h0);

    // Over-length, then recovery
    push(8'hAA); push(8'h01); push(8'h11);
    expect_ev(c_k_len, 8'h00, 8'h00);
    push(8'hAA); push(8'h01); push(8'h00); push(8'h01);
    expect_ev(c_k_val, 8'h01, 8'h00);
    wait_idle("len_err");

    // Maximum length 16: payload 0..15 sums to 0x78, chk = 30+10+78 = B8
    push(8'hAA); push(8'h30); push(8'h10);
    for (int i = 0; i < 16; i++) begin
      push(8'(i));
      expect_ev(c_k_wr, 8'(i), 8'(i));
    end
    push(8'hB8);
    expect_ev(c_k_val, 8'h30, 8'h10);
    wait_idle("max_len");

    // FIFO underrun mid-frame only stalls (15 idle cycles < timeout)
    push(8'hAA); push(8'h20); push(8'h03); push(8'h01);
    expect_ev(c_k_wr, 8'h00, 8'h01);
    repeat (25) @(negedge clk_in);
    check("stall_busy", {31'd0, busy}, 32'd1);
    push(8'h02); push(8'h03); push(8'h29);
    expect_ev(c_k_wr, 8'h01, 8'h02);
    expect_ev(c_k_wr, 8'h02, 8'h03);
    expect_ev(c_k_val, 8'h20, 8'h03);
    wait_idle("stall");

    // Timeout 20 cycles after the last strobe (strobe = read cycle + 1)
    push(8'hAA); push(8'h01);
    expect_ev(c_k_tmo, 8'h00, 8'h00);
    seen   = 1'b0;
    t_seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk_in);
      if (err_timeout === 1'b1) begin
        seen   = 1'b1;
        t_seen = $time;
      end
    end
    check("tmo_seen", {31'd0, seen}, 32'd1);
    check("tmo_delay", 32'((t_seen - last_take_t) / 10), 32'd21);
    wait_idle("timeout");
    check("tmo_busy", {31'd0, busy}, 32'd0);

    // Reset during payload clears every output at once
    push(8'hAA); push(8'h40); push(8'h03); push(8'h11);
    expect_ev(c_k_wr, 8'h00, 8'h11);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk_in);
      if (exp_q.size() == 0) seen = 1'b1;
    end
    check("rst_mid_reach", {31'd0, seen}, 32'd1);
    repeat (2) @(negedge clk_in);
    check("rst_mid_busy", {31'd0, busy}, 32'd1);
    #2 rst = 1'b1;
    #1 check("rst_mid_outs", {fifo_rd_en, pl_we, pl_addr, pl_data, frame_valid, frame_cmd,
                              frame_len, err_chk, err_len, err_timeout, busy}, 32'd0);
    @(negedge clk_in);
    rst = 1'b0;
    push(8'hAA); push(8'h41); push(8'h01); push(8'h77); push(8'hB9);
    expect_ev(c_k_wr, 8'h00, 8'h77);
    expect_ev(c_k_val, 8'h41, 8'h01);
    wait_idle("after_rst");
    check("final_cmd", {24'd0, frame_cmd}, 32'h41);
    check("final_len", {27'd0, frame_len}, 32'h1);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
